polaris_dbus_bridge: RTL

Downstream of the Polaris CPU D master port: converts each 64-bit-wide CPU data request (byte/half/word/dword, signed or unsigned) into one to four little-endian beats on a 16-bit Wishbone B3 classic bus. It assembles and sign- or zero-extends read data and returns a single-cycle acknowledge to the CPU. It is the only path between the CPU data port and external memory/peripherals.

---
 rtl/polaris_dbus_bridge.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/polaris_dbus_bridge.sv
// CPU 64-bit data port to 16-bit Wishbone B3 classic bridge.
// Optional misalignment trap: define POLARIS_DBUS_ALIGN_CHECK_EN.
module polaris_dbus_bridge (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    output logic [63:0] ddat_o,
    output logic        dack_o,
    output logic        derr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [63:0] wb_adr_o,
    output logic [1:0]  wb_sel_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic        req;
    logic        req_bad;
    logic [63:0] adr_start;
    logic [1:0]  cnt_start;

    logic        we_q;
    logic [1:0]  siz_q;
    logic        sgn_q;
    logic        b0_q;
    logic [63:0] adr_q;
    logic [63:0] wdat_q;
    logic [1:0]  cnt_q;
    logic [1:0]  idx_q;
    logic [63:0] asm_q;

    logic        busy;
    logic        done;
    logic        is_byte;
    logic [7:0]  rbyte;
    logic [63:0] rfmt;

    assign req = dcyc_i & dstb_i;

    // Start address is halfword aligned and rounded down to the access size.
    always_comb begin
        adr_start = {dadr_i[63:1], 1'b0};
        cnt_start = 2'd0;
        unique case (1'b1)
            dsiz_i == 2'b00: begin
                cnt_start = 2'd0;
            end
            dsiz_i == 2'b01: begin
                cnt_start = 2'd0;
            end
            dsiz_i == 2'b10: begin
                adr_start[1] = 1'b0;
                cnt_start    = 2'd1;
            end
            dsiz_i == 2'b11: begin
                adr_start[2:1] = 2'b00;
                cnt_start      = 2'd3;
            end
        endcase
    end

`ifdef POLARIS_DBUS_ALIGN_CHECK_EN
    logic misalign;
    logic err_q;

    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            dsiz_i == 2'b00: misalign = 1'b0;
            dsiz_i == 2'b01: misalign = dadr_i[0];
            dsiz_i == 2'b10: misalign = |dadr_i[1:0];
            dsiz_i == 2'b11: misalign = |dadr_i[2:0];
        endcase
    end

    assign req_bad = misalign;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_q <= 1'b0;
        end else if (state == IDLE && req) begin
            err_q <= misalign;
        end
    end

    assign derr_o = done & err_q;
`else
    assign req_bad = 1'b0;
    assign derr_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = req_bad ? DONE : BEAT;
                end
            end
            BEAT: begin
                if (wb_ack_i && cnt_q == 2'd0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            we_q   <= 1'b0;
            siz_q  <= 2'b00;
            sgn_q  <= 1'b0;
            b0_q   <= 1'b0;
            adr_q  <= '0;
            wdat_q <= '0;
            cnt_q  <= 2'd0;
            idx_q  <= 2'd0;
            asm_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        we_q   <= dwe_i;
                        siz_q  <= dsiz_i;
                        sgn_q  <= dsigned_i;
                        b0_q   <= dadr_i[0];
                        adr_q  <= adr_start;
                        wdat_q <= ddat_i;
                        cnt_q  <= cnt_start;
                        idx_q  <= 2'd0;
                        asm_q  <= '0;
                    end
                end
                BEAT: begin
                    if (wb_ack_i) begin
                        if (!we_q) begin
                            asm_q[{idx_q, 4'b0000} +: 16] <= wb_dat_i;
                        end
                        if (cnt_q != 2'd0) begin
                            adr_q  <= adr_q + 64'd2;
                            wdat_q <= {16'h0000, wdat_q[63:16]};
                            cnt_q  <= cnt_q - 2'd1;
                            idx_q  <= idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state == BEAT);
    assign done    = (state == DONE);
    assign is_byte = (siz_q == 2'b00);

    assign wb_cyc_o = busy;
    assign wb_stb_o = busy;
    assign wb_we_o  = busy & we_q;
    assign wb_adr_o = busy ? adr_q : 64'd0;

    always_comb begin
        wb_sel_o = 2'b00;
        wb_dat_o = 16'h0000;
        if (busy) begin
            if (is_byte) begin
                wb_sel_o = b0_q ? 2'b10 : 2'b01;
                wb_dat_o = {wdat_q[7:0], wdat_q[7:0]};
            end else begin
                wb_sel_o = 2'b11;
                wb_dat_o = wdat_q[15:0];
            end
        end
    end

    assign rbyte = b0_q ? asm_q[15:8] : asm_q[7:0];

    always_comb begin
        rfmt = asm_q;
        unique case (1'b1)
            siz_q == 2'b00: rfmt = {{56{sgn_q & rbyte[7]}}, rbyte};
            siz_q == 2'b01: rfmt = {{48{sgn_q & asm_q[15]}}, asm_q[15:0]};
            siz_q == 2'b10: rfmt = {{32{sgn_q & asm_q[31]}}, asm_q[31:0]};
            siz_q == 2'b11: rfmt = asm_q;
        endcase
    end

    // A trapped request never fills asm_q, so its rfmt is already zero.
    assign dack_o = done;
    assign ddat_o = (done && !we_q) ? rfmt : 64'd0;

endmodule
